// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch path: buffered entry layout,
// controller states and the bubble instruction shown to decode.
package fetch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular buffer of fetched {pc, instr} entries with a flush that
// empties it in one edge. The head is read straight from registered storage.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_data,
  output logic         full,
  output logic         empty,
  output fetch_entry_t head
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  fetch_entry_t  mem [DEPTH];

  // The caller never pushes while full without popping, nor pops while empty.
  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
      count_reg <= count_next;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      always_ff @(posedge clk_i) begin
        if (push && !flush && wr_ptr_reg == PW'(gi)) mem[gi] <= push_data;
      end
    end
  endgenerate

  assign full  = (count_reg == CW'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: owns the fetch PC, captures combinational
// instruction memory data into a FIFO and hands entries to decode.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        fetch_en_i,
  output logic [31:0] imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o
);

  fetch_state_e state_reg, state_next;
  logic [31:0]  pc_reg, pc_next;
  logic         push_en, pop_en;
  logic         fifo_full, fifo_empty;
  fetch_entry_t fifo_head, fifo_in;

  // Redirect targets are word aligned; the low bits are simply dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc_i[1:0];

  // Pop only depends on buffered state and decode's ready, never on the PC path.
  assign pop_en = !fifo_empty && instr_ready_i && !redirect_i;

  always_comb begin
    state_next = state_reg;
    push_en    = 1'b0;
    pc_next    = pc_reg;
    case (state_reg)
      IDLE: if (fetch_en_i) state_next = RUN;
      RUN: begin
        if (!fetch_en_i) state_next = IDLE;
        push_en = fetch_en_i && !redirect_i && (!fifo_full || pop_en);
      end
      default: state_next = IDLE;
    endcase
    if (redirect_i)   pc_next = {redirect_pc_i[31:2], 2'b00};
    else if (push_en) pc_next = pc_reg + 32'd4;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      pc_reg    <= RESET_PC;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
    end
  end

  assign fifo_in = '{pc: pc_reg, instr: imem_data_i};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .push     (push_en),
    .pop      (pop_en),
    .flush    (redirect_i),
    .push_data(fifo_in),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign imem_addr_o   = pc_reg;
  assign instr_valid_o = !fifo_empty;
  assign instr_o       = fifo_empty ? NOP_INSTR : fifo_head.instr;
  assign instr_pc_o    = fifo_empty ? 32'd0 : fifo_head.pc;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: stimulus queues the PCs decode should see,
// a negedge monitor pops and compares every accepted entry.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_ni, fetch_en, redirect, ready;
  logic [31:0] redirect_pc, imem_addr, imem_data, instr, instr_pc;
  logic        valid;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  // Memory word i holds 0x1000_0000 + i.
  assign imem_data = 32'h1000_0000 + {2'b00, imem_addr[31:2]};

  fetch_ctrl #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .fetch_en_i   (fetch_en),
    .imem_addr_o  (imem_addr),
    .imem_data_i  (imem_data),
    .redirect_i   (redirect),
    .redirect_pc_i(redirect_pc),
    .instr_valid_o(valid),
    .instr_ready_i(ready),
    .instr_o      (instr),
    .instr_pc_o   (instr_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] pc);
    return 32'h1000_0000 + {2'b00, pc[31:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back(pc);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_valid"}, {31'd0, valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'h0000_0013);
    check({tag, "_pc"},    instr_pc, 32'h0);
  endtask

  // Scoreboard monitor: every handshake the DUT completes must match the queue head.
  always @(negedge clk) begin
    if (rst_ni && valid && ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got pc %08h expected no entry", instr_pc);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        check("pop_pc", instr_pc, epc);
        check("pop_instr", instr, mem_word(epc));
        $display("pop pc=%08h instr=%08h", instr_pc, instr);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_ni = 1'b0; fetch_en = 1'b0; ready = 1'b0; redirect = 1'b0; redirect_pc = '0;
    step(); step();
    check_reset("reset");

    // Stall from start: two entries buffered, PC parked at 0x8.
    for (int i = 0; i < 6; i++) expect_pc(32'(4 * i));
    rst_ni = 1'b1; fetch_en = 1'b1;
    step();
    check("first_edge_valid", {31'd0, valid}, 32'd0);
    step();
    check("second_edge_valid", {31'd0, valid}, 32'd1);
    repeat (5) step();
    check("stall_addr", imem_addr, 32'h8);
    check("stall_head", instr_pc, 32'h0);

    // Stream six entries, then refill to full.
    ready = 1'b1;
    repeat (6) step();
    ready = 1'b0;
    repeat (2) step();
    check("full_addr", imem_addr, 32'd32);
    check("full_head", instr_pc, 32'd24);

    // Redirect while full with ready high: head discarded.
    expect_pc(32'h100); expect_pc(32'h104);
    ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0103;
    step();
    check("redir_addr", imem_addr, 32'h100);
    check("redir_valid", {31'd0, valid}, 32'd0);
    redirect = 1'b0;
    step();
    check("redir_valid_next", {31'd0, valid}, 32'd1);
    check("redir_head", instr_pc, 32'h100);
    step(); step();

    // Wrap past the top of the address space.
    expect_pc(32'hFFFF_FFF8); expect_pc(32'hFFFF_FFFC); expect_pc(32'h0); expect_pc(32'h4);
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    step();
    check("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    redirect = 1'b0;
    repeat (4) step();
    check("wrap_run_addr", imem_addr, 32'h8);
    check("wrap_run_head", instr_pc, 32'h4);

    // Drop fetch_en with one entry buffered.
    fetch_en = 1'b0; ready = 1'b0;
    repeat (3) step();
    check("idle_addr", imem_addr, 32'h8);
    check("idle_valid", {31'd0, valid}, 32'd1);
    check("idle_head", instr_pc, 32'h4);
    expect_pc(32'h8); expect_pc(32'hC);
    ready = 1'b1;
    step();
    check("idle_drained", {31'd0, valid}, 32'd0);
    check("idle_addr_after_pop", imem_addr, 32'h8);
    fetch_en = 1'b1;
    step();
    check("resume_valid", {31'd0, valid}, 32'd0);
    step(); step(); step();
    ready = 1'b0;
    step(); step();
    check("refill_addr", imem_addr, 32'd24);
    check("refill_head", instr_pc, 32'd16);

    // Reset while full and redirecting.
    rst_ni = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; ready = 1'b1;
    step();
    check_reset("midrst");
    rst_ni = 1'b1; redirect = 1'b0; fetch_en = 1'b0; ready = 1'b0;
    step();
    check("scoreboard_left", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction fetch controller sitting between the core's PC/redirect logic and the combinational-read instruction memory. It owns the fetch PC, drives the memory word address every cycle, captures the returned instruction with its PC into a small FIFO, and presents entries to decode through a valid/ready handshake. Branch and trap redirects flush buffered entries and restart fetch at the new address.

## Interface
- `RESET_PC`, 32'h0000_0000, fetch PC loaded on reset
- `DEPTH`, 2, FIFO entries; power of two, ≥2
- `clk_i` in 1: single clock, all state updates on rising edge
- `rst_ni` in 1: synchronous, active-low reset
- `fetch_en_i` in 1: permits fetching; low holds PC and FIFO contents
- `imem_addr_o` out 32: byte address to instruction memory; always `pc_q`
- `imem_data_i` in 32: instruction word returned combinationally for `imem_addr_o`
- `redirect_i` in 1: flush and restart fetch
- `redirect_pc_i` in 32: new fetch address; bits [1:0] forced to 0
- `instr_valid_o` out 1: FIFO head valid
- `instr_ready_i` in 1: decode accepts head this cycle
- `instr_o` out 32: head instruction; NOP 32'h0000_0013 when not valid
- `instr_pc_o` out 32: head PC; 0 when not valid

## Operation
- FSM `IDLE`, `RUN`; reset → `IDLE`.
- `IDLE`: no push. `fetch_en_i`=1 → `RUN` next edge. Redirect in `IDLE` loads PC and flushes; state stays `IDLE`.
- `RUN`: `fetch_en_i`=0 → `IDLE`; FIFO is kept and decode may still pop.
- Push in `RUN` when `fetch_en_i`=1, `redirect_i`=0, and (`count`<`DEPTH` or pop this cycle). Entry = {`pc_q`, `imem_data_i`}; then `pc_q` ← `pc_q`+4, modulo 2^32 (32'hFFFF_FFFC → 0).
- Pop when `instr_valid_o` && `instr_ready_i` && !`redirect_i`.
- Simultaneous push+pop when full: allowed; count unchanged.
- `redirect_i`=1 has priority over push and pop: `count`←0, read/write pointers←0, `pc_q`←{`redirect_pc_i`[31:2],2'b00}. Head offered that cycle is discarded even if `instr_ready_i`=1.
- `count` is `$clog2(DEPTH)+1` bits wide; pointers wrap modulo `DEPTH`.
- Reset mid-operation: all state returns to reset values on the next edge, regardless of other inputs.

## Timing
- Reset values: `imem_addr_o`=`RESET_PC`, `instr_valid_o`=0, `instr_o`=32'h0000_0013, `instr_pc_o`=0; state `IDLE`, `count`=0.
- `fetch_en_i` sampled high at edge N (`IDLE`→`RUN`); first push at edge N+1; `instr_valid_o` high after edge N+1.
- Redirect at edge R: `imem_addr_o` = new PC after R; first new entry pushed at R+1, valid after R+1. Redirect-to-valid latency is 1 cycle.
- Steady state: 1 instruction per cycle with `instr_ready_i` held high.
- Outputs depend only on registered state. `instr_ready_i` has no combinational path to `imem_addr_o`.

## Structure
- Package `fetch_pkg`: `fetch_entry_t` struct {pc[31:0], instr[31:0]}, `fetch_state_e` {IDLE, RUN}, `NOP_INSTR`=32'h0000_0013.
- Sub-module `fetch_fifo`, parameterised by `DEPTH`, storing `fetch_entry_t`, with ports push, pop, flush, full, empty, head. The FSM and PC register stay in `fetch_ctrl`.

## Test plan
- Reset, `fetch_en_i`=1, `instr_ready_i`=1, memory word i = 32'h1000_0000+i: entries arrive at PC 0,4,8,… with matching data, one per cycle, beginning 2 edges after reset release.
- `instr_ready_i`=0 for 5 cycles with `DEPTH`=2: exactly 2 entries buffered, `imem_addr_o` stalls at 0x8, and ordering is preserved on release.
- FIFO full, then assert `redirect_i` with `redirect_pc_i`=0x0000_0103 and `instr_ready_i`=1: no pop occurs, count→0, next entry PC=0x100, valid one cycle later.
- `redirect_pc_i`=0xFFFF_FFF8: fetch PCs are 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Drop `fetch_en_i` mid-stream with 1 entry buffered: `IDLE`, PC frozen, remaining entry still poppable. Re-enable: fetch resumes at the frozen PC.
- Drop `rst_ni` for 1 cycle while full and redirecting: all outputs at reset values, `imem_addr_o`=`RESET_PC`.
